uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Byte-stream command decoder directly downstream of the UART receiver (uart_rx rx_data/rx_en).
//  Frames host bytes, verifies checksum and drives registered servo pan/tilt targets and a tracking enable.
//  Also emits one decoded-command strobe per valid frame for other consumers.
//  Frame format: HDR0, HDR1, CMD, DATA_H, DATA_L, CHK, where CHK = (CMD + DATA_H + DATA_L) mod 256.
// PARAMETERS
//  HDR0      8'hAA    first header byte
//  HDR1      8'h55    second header byte
//  TIMEOUT   16'd20000  max clk cycles between bytes inside a frame (~3 byte times at BPS_NUM 645)
//  POS_MIN   12'd500  lower clamp for pan/tilt target
//  POS_MAX   12'd2500 upper clamp for pan/tilt target
//  POS_INIT  12'd1500 reset value of pan/tilt target
// PORTS
//  clk        in   1   system clock (same domain as uart_rx)
//  reset      in   1   synchronous, active-low reset
//  rx_data    in   8   received byte, valid when rx_en=1
//  rx_en      in   1   1-cycle byte-valid strobe
//  cmd_valid  out  1   1-cycle strobe: good frame decoded
//  cmd_id     out  8   CMD of last good frame
//  cmd_data   out  16  {DATA_H,DATA_L} of last good frame
//  pan_pos    out  12  pan servo target
//  tilt_pos   out  12  tilt servo target
//  track_en   out  1   auto-tracking enable
//  frame_err  out  1   1-cycle strobe: checksum fail or inter-byte timeout
//  good_cnt   out  8   count of good frames, wraps 255->0
// BEHAVIOUR
//  Reset (reset=0 at a clk edge): state=S_IDLE, cmd_valid=0, frame_err=0, cmd_id=0, cmd_data=0,
//   pan_pos=tilt_pos=POS_INIT, track_en=0, good_cnt=0, timeout counter=0. Any partial frame is discarded.
//  FSM advances only on cycles where rx_en=1:
//   S_IDLE: byte==HDR0 -> S_HDR1; otherwise stay in S_IDLE.
//   S_HDR1: byte==HDR1 -> S_CMD; byte==HDR0 -> stay in S_HDR1 (resync); otherwise -> S_IDLE.
//   S_CMD -> S_DH -> S_DL -> S_CHK: each byte is captured; the running sum is kept in 8 bits (wraps).
//   S_CHK: CHK==sum -> good frame; otherwise frame_err pulses. Both outcomes -> S_IDLE.
//   No error is raised for bytes discarded in S_IDLE/S_HDR1.
//  Good frame, updated on the cycle after the CHK byte's rx_en (latency 1):
//   cmd_valid=1 for exactly 1 cycle; cmd_id and cmd_data are loaded; good_cnt increments by 1.
//   CMD 8'h01: pan_pos = clamp(cmd_data[11:0], POS_MIN, POS_MAX); cmd_data[15:12] ignored.
//   CMD 8'h02: tilt_pos = clamp(cmd_data[11:0], POS_MIN, POS_MAX).
//   CMD 8'h03: track_en = cmd_data[0].
//   Any other CMD: cmd_valid/cmd_id/cmd_data/good_cnt update as above; pan/tilt/track_en unchanged.
//  Timeout:
//   The counter clears on every rx_en. It counts while state != S_IDLE and holds at 0 in S_IDLE.
//   When it reaches TIMEOUT-1 with no rx_en: state -> S_IDLE and frame_err pulses on the next cycle.
//   rx_en on the same cycle as expiry: the byte is processed and the timeout is cancelled.
//  cmd_valid and frame_err are never high in the same cycle. Outputs are all registered.
//  rx_en is assumed to be at most 1 cycle wide and never asserted on consecutive cycles.
// TESTING
//  1. Bytes AA 55 01 05 DC E2 -> cmd_valid 1 cycle after the last rx_en; pan_pos=1500 (0x5DC); good_cnt=1.
//  2. AA 55 02 0F A0 B1 (0xFA0=4000) -> tilt_pos clamped to 2500.
//     AA 55 02 00 64 66 (100) -> tilt_pos=500.
//  3. AA 55 01 05 DC 00 (bad CHK) -> frame_err 1 cycle, no cmd_valid, pan_pos unchanged, good_cnt unchanged.
//  4. AA 55 03 00 01 04 -> track_en=1. Then AA AA 55 03 00 00 03 -> resync, track_en=0.
//  5. AA 55 01 then idle >TIMEOUT cycles -> frame_err pulse, FSM back to S_IDLE.
//     A following full valid frame decodes normally.
//  6. reset=0 mid-frame after AA 55 01, then release and send 05 DC E2 -> no cmd_valid.
//     Outputs stay at reset values: pan_pos=1500, good_cnt=0.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if
//  Groups the byte-stream input and the decoded-command outputs of
//  uart_cmd_parser.
//  master : byte source / consumer side (drives rx_data/rx_en, reads results)
//  slave  : the parser (reads rx_data/rx_en, drives results)
//  Signals:
//   rx_data   [7:0]  received byte, valid when rx_en=1
//   rx_en            1-cycle byte-valid strobe
//   cmd_valid        1-cycle strobe, good frame decoded
//   cmd_id    [7:0]  CMD of last good frame
//   cmd_data  [15:0] {DATA_H,DATA_L} of last good frame
//   pan_pos   [11:0] pan servo target
//   tilt_pos  [11:0] tilt servo target
//   track_en         auto-tracking enable
//   frame_err        1-cycle strobe, checksum fail or inter-byte timeout
//   good_cnt  [7:0]  count of good frames (wraps)
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_en;
  logic        cmd_valid;
  logic [7:0]  cmd_id;
  logic [15:0] cmd_data;
  logic [11:0] pan_pos;
  logic [11:0] tilt_pos;
  logic        track_en;
  logic        frame_err;
  logic [7:0]  good_cnt;

  modport master (
    output rx_data, rx_en,
    input  cmd_valid, cmd_id, cmd_data, pan_pos, tilt_pos, track_en, frame_err, good_cnt
  );

  modport slave (
    input  rx_data, rx_en,
    output cmd_valid, cmd_id, cmd_data, pan_pos, tilt_pos, track_en, frame_err, good_cnt
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//  Frames the byte stream coming out of uart_rx (HDR0 HDR1 CMD DATA_H DATA_L CHK),
//  verifies CHK = (CMD + DATA_H + DATA_L) mod 256 and, for good frames, updates
//  the registered pan/tilt targets (clamped) and the tracking enable.
//  Ports:
//   clk    system clock (same domain as uart_rx)
//   reset  synchronous, active-low
//   bus    uart_cmd_parser_if.slave: rx_data/rx_en in; cmd_valid, cmd_id,
//          cmd_data, pan_pos, tilt_pos, track_en, frame_err, good_cnt out
module uart_cmd_parser #(
  parameter logic [7:0]  HDR0     = 8'hAA,
  parameter logic [7:0]  HDR1     = 8'h55,
  parameter logic [15:0] TIMEOUT  = 16'd20000,
  parameter logic [11:0] POS_MIN  = 12'd500,
  parameter logic [11:0] POS_MAX  = 12'd2500,
  parameter logic [11:0] POS_INIT = 12'd1500
) (
  input  logic              clk,
  input  logic              reset,
  uart_cmd_parser_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR1, S_CMD, S_DH, S_DL, S_CHK
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic [7:0]  cmd_p0, dh_p0, dl_p0, sum_p0;
  logic        good_frame, bad_frame, expire;

  function automatic logic [11:0] clamp_pos(input logic [11:0] v);
    if (v < POS_MIN)      return POS_MIN;
    else if (v > POS_MAX) return POS_MAX;
    else                  return v;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: bytes drive the framing; silence inside a frame aborts it
  always_comb begin
    state_nxt = state;
    if (bus.rx_en) begin
      unique case (state)
        S_IDLE:  if (bus.rx_data == HDR0) state_nxt = S_HDR1;
        S_HDR1: begin
          if (bus.rx_data == HDR1)      state_nxt = S_CMD;
          else if (bus.rx_data == HDR0) state_nxt = S_HDR1;  // resync on repeated header
          else                          state_nxt = S_IDLE;
        end
        S_CMD:   state_nxt = S_DH;
        S_DH:    state_nxt = S_DL;
        S_DL:    state_nxt = S_CHK;
        S_CHK:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end else if (expire) begin
      state_nxt = S_IDLE;
    end
  end

  // Output decode: frame verdicts and timeout expiry (a byte on the expiry cycle wins)
  always_comb begin
    good_frame = bus.rx_en && (state == S_CHK) && (bus.rx_data == sum_p0);
    bad_frame  = bus.rx_en && (state == S_CHK) && (bus.rx_data != sum_p0);
    expire     = !bus.rx_en && (state != S_IDLE) && (tmo_cnt == TIMEOUT - 16'd1);
  end

  // Inter-byte timeout counter
  always_ff @(posedge clk) begin
    if (!reset)                                      tmo_cnt <= 16'd0;
    else if (bus.rx_en || state == S_IDLE || expire) tmo_cnt <= 16'd0;
    else                                             tmo_cnt <= tmo_cnt + 16'd1;
  end

  // Stage p0: payload capture and running 8-bit checksum
  always_ff @(posedge clk) begin
    if (bus.rx_en) begin
      unique case (state)
        S_CMD: begin
          cmd_p0 <= bus.rx_data;
          sum_p0 <= bus.rx_data;
        end
        S_DH: begin
          dh_p0  <= bus.rx_data;
          sum_p0 <= sum_p0 + bus.rx_data;
        end
        S_DL: begin
          dl_p0  <= bus.rx_data;
          sum_p0 <= sum_p0 + bus.rx_data;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered command results
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.cmd_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.cmd_id    <= 8'd0;
      bus.cmd_data  <= 16'd0;
      bus.pan_pos   <= POS_INIT;
      bus.tilt_pos  <= POS_INIT;
      bus.track_en  <= 1'b0;
      bus.good_cnt  <= 8'd0;
    end else begin
      bus.cmd_valid <= good_frame;
      bus.frame_err <= bad_frame | expire;
      if (good_frame) begin
        bus.cmd_id   <= cmd_p0;
        bus.cmd_data <= {dh_p0, dl_p0};
        bus.good_cnt <= bus.good_cnt + 8'd1;
        unique case (cmd_p0)
          8'h01:   bus.pan_pos  <= clamp_pos({dh_p0[3:0], dl_p0});
          8'h02:   bus.tilt_pos <= clamp_pos({dh_p0[3:0], dl_p0});
          8'h03:   bus.track_en <= dl_p0[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  localparam int TMO = 300;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.TIMEOUT(16'(TMO))) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: frame buffer of bytes accepted so far, plus silence length
  logic [7:0]  fbuf[$];
  int          silence;
  logic        m_valid, m_err, m_track;
  logic [7:0]  m_id, m_cnt;
  logic [15:0] m_data;
  logic [11:0] m_pan, m_tilt;

  function automatic logic [11:0] ref_clamp(input int v);
    if (v < 500)  return 12'd500;
    if (v > 2500) return 12'd2500;
    return 12'(v);
  endfunction

  task automatic model_step(input logic en, input logic [7:0] b, input logic rst_n);
    logic [7:0] s;
    int v;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!rst_n) begin
      fbuf.delete();
      silence = 0;
      m_id = 8'd0; m_data = 16'd0; m_pan = 12'd1500; m_tilt = 12'd1500;
      m_track = 1'b0; m_cnt = 8'd0;
    end else if (en) begin
      silence = 0;
      case (fbuf.size())
        0: if (b == 8'hAA) fbuf.push_back(b);
        1: begin
          if (b == 8'h55) fbuf.push_back(b);
          else if (b != 8'hAA) fbuf.delete();
        end
        2, 3, 4: fbuf.push_back(b);
        default: begin
          s = fbuf[2] + fbuf[3] + fbuf[4];
          if (b == s) begin
            m_valid = 1'b1;
            m_id    = fbuf[2];
            m_data  = {fbuf[3], fbuf[4]};
            m_cnt   = m_cnt + 8'd1;
            v = int'(m_data) % 4096;
            if (m_id == 8'h01) m_pan = ref_clamp(v);
            if (m_id == 8'h02) m_tilt = ref_clamp(v);
            if (m_id == 8'h03) m_track = m_data[0];
          end else begin
            m_err = 1'b1;
          end
          fbuf.delete();
        end
      endcase
    end else if (fbuf.size() > 0) begin
      silence++;
      if (silence == TMO) begin
        fbuf.delete();
        silence = 0;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic en, input logic [7:0] b, input logic rst_n);
    bus.rx_en   = en;
    bus.rx_data = b;
    reset       = rst_n;
    @(posedge clk);
    model_step(en, b, rst_n);
    #1;
    bus.rx_en = 1'b0;
    chk("cmd_valid", 32'(bus.cmd_valid), 32'(m_valid));
    chk("frame_err", 32'(bus.frame_err), 32'(m_err));
    chk("cmd_id",    32'(bus.cmd_id),    32'(m_id));
    chk("cmd_data",  32'(bus.cmd_data),  32'(m_data));
    chk("pan_pos",   32'(bus.pan_pos),   32'(m_pan));
    chk("tilt_pos",  32'(bus.tilt_pos),  32'(m_tilt));
    chk("track_en",  32'(bus.track_en),  32'(m_track));
    chk("good_cnt",  32'(bus.good_cnt),  32'(m_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b1);
  endtask

  // gap = idle cycles before the byte (>=1 keeps rx_en non-consecutive)
  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    tick(1'b1, b, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] dh, input logic [7:0] dl,
                            input logic [7:0] ck);
    send(8'hAA, 1); send(8'h55, 1); send(c, 1); send(dh, 2); send(dl, 1); send(ck, 3);
  endtask

  initial begin
    logic [7:0] c, dh, dl, ck;
    int g;
    bus.rx_en   = 1'b0;
    bus.rx_data = 8'h00;
    silence     = 0;

    // Reset state
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("rst_pan", 32'(bus.pan_pos), 32'd1500);
    chk("rst_cnt", 32'(bus.good_cnt), 32'd0);
    idle(2);

    // 1: pan command
    send_frame(8'h01, 8'h05, 8'hDC, 8'hE2);
    chk("t1_valid", 32'(bus.cmd_valid), 32'd1);
    chk("t1_cnt", 32'(bus.good_cnt), 32'd1);
    idle(1);
    chk("t1_pulse_end", 32'(bus.cmd_valid), 32'd0);

    // 2: tilt clamped high, then low
    send_frame(8'h02, 8'h0F, 8'hA0, 8'hB1);
    chk("t2_tilt_hi", 32'(bus.tilt_pos), 32'd2500);
    send_frame(8'h02, 8'h00, 8'h64, 8'h66);
    chk("t2_tilt_lo", 32'(bus.tilt_pos), 32'd500);

    // 3: bad checksum
    send_frame(8'h01, 8'h05, 8'hDC, 8'h00);
    chk("t3_err", 32'(bus.frame_err), 32'd1);
    chk("t3_cnt", 32'(bus.good_cnt), 32'd3);

    // 4: tracking on, then resync on repeated header and tracking off
    send_frame(8'h03, 8'h00, 8'h01, 8'h04);
    chk("t4_track_on", 32'(bus.track_en), 32'd1);
    send(8'hAA, 2);
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    chk("t4_track_off", 32'(bus.track_en), 32'd0);

    // 5: timeout after partial frame, then a normal frame
    send(8'hAA, 1); send(8'h55, 1); send(8'h01, 1);
    idle(TMO + 5);
    send_frame(8'h01, 8'h07, 8'hD0, 8'hD8);
    chk("t5_pan", 32'(bus.pan_pos), 32'd2000);

    // Boundary: byte exactly at the expiry cycle is accepted; one later is not
    send(8'hAA, 1); send(8'h55, 1); send(8'h01, TMO - 1);
    send(8'h03, 1); send(8'h00, 1); send(8'h04, 1);
    chk("tmo_edge_pan", 32'(bus.pan_pos), 32'd768);
    send(8'hAA, 1); send(8'h55, TMO);
    send(8'h01, 2);

    // Randomized frames, garbage and occasional long gaps
    for (int f = 0; f < 400; f++) begin
      case ($urandom_range(0, 3))
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        default: c = 8'($urandom);
      endcase
      dh = 8'($urandom);
      dl = 8'($urandom);
      ck = c + dh + dl;
      if ($urandom_range(0, 5) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) send(8'($urandom), $urandom_range(1, 3));
      g = ($urandom_range(0, 40) == 0) ? (TMO - 1 + $urandom_range(0, 2)) : $urandom_range(1, 4);
      send(8'hAA, $urandom_range(1, 4));
      send(8'h55, $urandom_range(1, 4));
      send(c, $urandom_range(1, 4));
      send(dh, g);
      send(dl, $urandom_range(1, 4));
      send(ck, $urandom_range(1, 4));
    end
    idle(3);

    // 6: reset in mid-frame discards it
    send(8'hAA, 1); send(8'h55, 1); send(8'h01, 1);
    tick(1'b0, 8'h00, 1'b0);
    idle(1);
    send(8'h05, 1); send(8'hDC, 1); send(8'hE2, 1);
    idle(2);
    chk("t6_pan", 32'(bus.pan_pos), 32'd1500);
    chk("t6_cnt", 32'(bus.good_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
